// File: rtl/counter_sched_pkg.sv
// Shared types and constants for the two-requester burst scheduler.
package counter_sched_pkg;

  localparam int unsigned CntWDefault = 8;
  localparam int unsigned NumReq      = 2;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } state_t;

endpackage

// File: rtl/counter_sched_rr_arbiter2.sv
// Two-way round-robin grant select; ptr names the requester that wins a tie.
module rr_arbiter2
  import counter_sched_pkg::*;
(
  input  logic [NumReq-1:0] req,
  input  logic              ptr,
  input  logic              en,
  output logic [NumReq-1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (en) begin
      if (req[0] && (!req[1] || !ptr)) begin
        gnt = 2'b01;
      end else if (req[1]) begin
        gnt = 2'b10;
      end
    end
  end

endmodule

// File: rtl/counter_sched.sv
// Burst scheduler: arbitrates two requesters, drives an external counter for
// the granted burst length, and flags a mismatch in the returned count.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NumReq-1:0] req,
  input  logic [CNT_W-1:0]  len0,
  input  logic [CNT_W-1:0]  len1,
  input  logic              pause,
  input  logic [CNT_W-1:0]  validin,
  output logic              load,
  output logic              validtocounter,
  output logic [NumReq-1:0] gnt,
  output logic              busy,
  output logic [NumReq-1:0] done,
  output logic              err
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [NumReq-1:0] gnt_q, gnt_d;
  logic              ptr_q, ptr_d;
  logic              err_q, err_d;
  logic [NumReq-1:0] arb_gnt;
  logic [CNT_W-1:0]  arb_len;

  rr_arbiter2 u_arb (
    .req (req),
    .ptr (ptr_q),
    .en  (state_q == StIdle),
    .gnt (arb_gnt)
  );

  assign arb_len = arb_gnt[1] ? len1 : len0;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    len_d   = len_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          gnt_d   = arb_gnt;
          len_d   = arb_len;
          rem_d   = arb_len;
          state_d = StLoad;
        end
      end
      StLoad: begin
        state_d = (rem_q == '0) ? StDone : StRun;
      end
      StRun: begin
        if (!pause) begin
          // rem_q is never zero here, but guard so it can never wrap.
          if (rem_q != '0) begin
            rem_d = rem_q - CNT_W'(1);
          end
          if (rem_q <= CNT_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        gnt_d   = '0;
        ptr_d   = ~gnt_q[1];
        state_d = StIdle;
        if (validin != len_q) begin
          err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
      len_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    load           = (state_q == StLoad);
    validtocounter = (state_q == StRun) && !pause;
    busy           = (state_q != StIdle);
    done           = (state_q == StDone) ? gnt_q : '0;
    gnt            = gnt_q;
    err            = err_q;
  end

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched with a burst scoreboard and a counter model.
module tb_counter_sched;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req;
  logic [W-1:0] len0, len1;
  logic         pause;
  logic [W-1:0] validin;
  logic         load, validtocounter, busy, err;
  logic [1:0]   gnt, done;

  logic [W-1:0] cnt;
  logic         force_v;
  logic [W-1:0] force_val;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] g;
    int         len;
    int         run;
  } exp_t;
  exp_t sb[$];

  logic [1:0] cur_gnt;
  int  en_cnt, run_cnt, cyc, done_cyc;
  bit  have_done, prev_load, b2b;

  counter_sched #(.CNT_W(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .len0           (len0),
    .len1           (len1),
    .pause          (pause),
    .validin        (validin),
    .load           (load),
    .validtocounter (validtocounter),
    .gnt            (gnt),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  always #5 clk = ~clk;

  // External counter: cleared by load, incremented by validtocounter.
  always @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else if (load) cnt <= '0;
    else if (validtocounter) cnt <= cnt + 1'b1;
  end
  assign validin = force_v ? force_val : cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] g, input int len, input int run);
    exp_t e;
    e.g = g; e.len = len; e.run = run;
    sb.push_back(e);
  endtask

  task automatic wait_load(input int lim, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (load !== 1'b1 && n < lim);
    chk("load_seen", load, 1);
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done === 2'b00 && n < lim);
    chk("done_seen", |done, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_load"}, load, 0);
    chk({tag, "_vtc"}, validtocounter, 0);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Burst monitor: grant stability, enable/RUN counts, scoreboard pop on done.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      sb.delete();
      en_cnt = 0;
      run_cnt = 0;
      have_done = 0;
      prev_load = 0;
    end else begin
      if (load) begin
        chk("load_one_cycle", prev_load, 0);
        if (b2b && have_done) chk("b2b_gap", cyc - done_cyc, 2);
        if (sb.size() > 0) begin
          chk("gnt_at_load", gnt, sb[0].g);
          cur_gnt = sb[0].g;
        end else begin
          chk("load_unexpected", load, 0);
        end
        en_cnt = 0;
        run_cnt = 0;
      end else if (busy) begin
        chk("gnt_hold", gnt, cur_gnt);
      end else begin
        chk("gnt_idle", gnt, 0);
      end
      if (busy && !load && done == 2'b00) run_cnt++;
      if (validtocounter) en_cnt++;
      if (done != 2'b00) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", done, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_owner", done, e.g);
          chk("enable_count", en_cnt, e.len);
          if (e.run >= 0) chk("run_cycles", run_cnt, e.run);
        end
        done_cyc = cyc;
        have_done = 1;
      end
      prev_load = load;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0; req = '0; len0 = '0; len1 = '0; pause = 1'b0;
    force_v = 1'b0; force_val = '0;
    cyc = 0; done_cyc = 0; b2b = 0; cur_gnt = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    step(); rst = 1'b1;

    // Three back-to-back bursts with both requesters held.
    step(); len0 = 8'd2; len1 = 8'd3;
    push(2'b01, 2, 2); push(2'b10, 3, 3); push(2'b01, 2, 2);
    b2b = 1; req = 2'b11;
    for (int k = 0; k < 3; k++) wait_done(50);
    step(); req = 2'b00; b2b = 0;

    // Single burst len 5, with one-cycle latency check.
    step(); len0 = 8'd5; push(2'b01, 5, 5); req = 2'b01;
    wait_load(10, n);
    chk("latency", n, 2);
    step(); req = 2'b00;
    chk("load_dropped", load, 0);
    wait_done(20);
    step(); chk("err_clean", err, 0);

    // len1=4 with a three-cycle pause mid-RUN.
    step(); len1 = 8'd4; push(2'b10, 4, 7); req = 2'b10;
    wait_load(10, n);
    step(); req = 2'b00;
    step();
    step(); pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("paused_vtc", validtocounter, 0);
    end
    step(); pause = 1'b0;
    wait_done(20);

    // Zero length, then maximum length.
    step(); len0 = 8'd0; push(2'b01, 0, 0); req = 2'b01;
    wait_load(10, n);
    step(); req = 2'b00;
    wait_done(10);
    step(); len0 = 8'd255; push(2'b01, 255, 255); req = 2'b01;
    wait_load(10, n);
    step(); req = 2'b00;
    wait_done(300);
    step(); chk("err_after_max", err, 0);

    // Wrong count returned: err sets and stays through a good burst.
    step(); force_v = 1'b1; force_val = 8'd2; len0 = 8'd3;
    push(2'b01, 3, 3); req = 2'b01;
    wait_load(10, n);
    step(); req = 2'b00;
    wait_done(20);
    step(); chk("err_set", err, 1);
    force_v = 1'b0;
    step(); len0 = 8'd2; push(2'b01, 2, 2); req = 2'b01;
    wait_load(10, n);
    step(); req = 2'b00;
    wait_done(20);
    step(); chk("err_sticky", err, 1);

    // Reset mid-RUN aborts the burst; next request is granted normally.
    step(); len0 = 8'd10; push(2'b01, 10, 10); req = 2'b01;
    wait_load(10, n);
    step(); req = 2'b00;
    step();
    step(); rst = 1'b0;
    #1;
    chk_zero("abort");
    @(negedge clk);
    @(negedge clk);
    chk("abort_no_done", done, 0);
    step(); rst = 1'b1;
    step(); len1 = 8'd3; push(2'b10, 3, 3); req = 2'b10;
    wait_load(10, n);
    chk("latency_after_reset", n, 2);
    step(); req = 2'b00;
    wait_done(20);
    step();
    chk("sb_drained", sb.size(), 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_sched.md
COUNTER_SCHED -- requirements
Module: counter_sched

Interface
REQ-001 Parameter: CNT_W, default 8, width of burst length and of the counter value fed back.
REQ-002 Port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  2  burst request, one bit per requester, level-sensitive.
REQ-005 Port: len0  input  CNT_W  burst length for requester 0, sampled at grant.
REQ-006 Port: len1  input  CNT_W  burst length for requester 1, sampled at grant.
REQ-007 Port: pause  input  1  stalls the burst; validtocounter forced low while high.
REQ-008 Port: validin  input  CNT_W  counter value returned by the counter.
REQ-009 Port: load  output  1  one-cycle clear pulse to the counter.
REQ-010 Port: validtocounter  output  1  counter increment enable.
REQ-011 Port: gnt  output  2  one-hot grant of the burst owner.
REQ-012 Port: busy  output  1  high in any state other than IDLE.
REQ-013 Port: done  output  2  one-cycle completion pulse for the burst owner.
REQ-014 Port: err  output  1  sticky count-mismatch flag.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, RUN and DONE, registered and one-hot or binary encoded.
REQ-016 In IDLE, a clock edge with req != 0 SHALL select a winner, latch its length into rem, set gnt and enter LOAD.
REQ-017 Arbitration SHALL be round-robin: on simultaneous requests, the requester not granted last wins; after reset, requester 0 wins.
REQ-018 Latency SHALL be one cycle: req sampled at edge N gives load=1 in the cycle after edge N.
REQ-019 LOAD SHALL assert load for exactly one cycle, with validtocounter=0, then go to RUN, or to DONE if the latched length is 0.
REQ-020 RUN SHALL assert validtocounter = !pause each cycle, decrementing rem on each enabled cycle.
REQ-021 An enabled RUN cycle with rem==1 SHALL be the last one; the next state is DONE.
REQ-022 pause in LOAD or DONE SHALL have no effect; pause held in RUN SHALL stall indefinitely with no timeout.
REQ-023 DONE SHALL pulse done[owner] for one cycle, clear gnt, update the round-robin pointer and return to IDLE.
REQ-024 gnt SHALL stay constant from LOAD through DONE inclusive; it SHALL be all-zero in IDLE.
REQ-025 Requests SHALL be sampled only in IDLE; req changes during a burst SHALL be ignored, and the burst SHALL complete.
REQ-026 In DONE, if validin != latched length (mod 2^CNT_W), err SHALL set and remain set until reset.
REQ-027 A length of 2^CNT_W-1 SHALL produce exactly that many enable cycles; rem SHALL never underflow.
REQ-028 A back-to-back request SHALL be accepted in the IDLE cycle after DONE, giving a minimum gap of one idle cycle between bursts.

Reset
REQ-029 rst low SHALL asynchronously force state=IDLE, rem=0, pointer=requester 0, and load, validtocounter, gnt, busy, done and err to 0.
REQ-030 Reset during a burst SHALL abort it with no done pulse; the first request after release SHALL be arbitrated fresh.

Structure
REQ-031 Package counter_sched_pkg SHALL hold the state type, the CNT_W default and the requester count constant (2).
REQ-032 Grant selection SHALL be the sub-module rr_arbiter2, which takes req, the pointer and an enable, and returns a one-hot grant.
REQ-033 All outputs SHALL be driven from registers or from state decode only; there SHALL be no combinational path from req to gnt.

Verification
REQ-034 req=01 with len0=5 and pause=0 -> load for 1 cycle, validtocounter for 5 consecutive cycles, done=01 once, gnt=01 throughout, err=0 with validin=5.
REQ-035 req=11 held across three bursts -> grants in order 01, 10, 01, with exactly one idle cycle between bursts.
REQ-036 len1=4, pause high for 3 cycles mid-RUN -> 4 enable cycles spread over 7 RUN cycles, done=10 once.
REQ-037 len0=0 -> LOAD, then DONE, zero validtocounter cycles, done=01; len0=255 -> 255 enable cycles.
REQ-038 rst low during RUN -> all outputs 0 immediately, no done pulse; the next req=10 is granted normally.
REQ-039 len0=3 with validin returning 2 at DONE -> err=1, persisting through later correct bursts until reset.
